// File: rtl/csr_port_sched_pkg.sv
// Shared definitions for the CSR port scheduler: CSR numbers, exception codes, field masks, FSM states.
// CSR_SCHED_BADV_EN adds the EX_BADV state for ADEF/ALE exceptions.
package csr_port_sched_pkg;

  localparam int CSR_NUM_W = 14;
  localparam int DATA_W    = 32;

  localparam logic [CSR_NUM_W-1:0] CSR_CRMD   = 14'h000;
  localparam logic [CSR_NUM_W-1:0] CSR_PRMD   = 14'h001;
  localparam logic [CSR_NUM_W-1:0] CSR_ESTAT  = 14'h005;
  localparam logic [CSR_NUM_W-1:0] CSR_ERA    = 14'h006;
  localparam logic [CSR_NUM_W-1:0] CSR_BADV   = 14'h007;
  localparam logic [CSR_NUM_W-1:0] CSR_EENTRY = 14'h00C;

  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;

  localparam logic [DATA_W-1:0] MASK_ALL        = 32'hFFFF_FFFF;
  localparam logic [DATA_W-1:0] MASK_PLV_IE     = 32'h0000_0007;
  localparam logic [DATA_W-1:0] MASK_ESTAT_CODE = 32'h7FFF_0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CSR,
    S_EX_ERA,
    S_EX_CRMD_RD,
    S_EX_PRMD,
    S_EX_CRMD,
    S_EX_ESTAT,
`ifdef CSR_SCHED_BADV_EN
    S_EX_BADV,
`endif
    S_EX_ENTRY,
    S_ERTN_PRMD_RD,
    S_ERTN_CRMD,
    S_ERTN_ERA_RD
  } state_e;

  function automatic logic ecode_has_badv(input logic [5:0] ecode);
    return (ecode == ECODE_ADEF) || (ecode == ECODE_ALE);
  endfunction

endpackage

// File: rtl/csr_port_sched_if.sv
// WB-stage request/response bundle for the CSR port scheduler.
// master = WB stage, slave = scheduler.
interface csr_port_sched_if;
  import csr_port_sched_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_csr_re;
  logic                 req_csr_we;
  logic [CSR_NUM_W-1:0] req_csr_num;
  logic [DATA_W-1:0]    req_wmask;
  logic [DATA_W-1:0]    req_wvalue;
  logic                 req_ex;
  logic [5:0]           req_ecode;
  logic [8:0]           req_esubcode;
  logic                 req_ertn;
  logic [DATA_W-1:0]    req_pc;
  logic [DATA_W-1:0]    req_badv;
  logic                 rsp_valid;
  logic [DATA_W-1:0]    rsp_rdata;

  modport master (
    output req_valid, req_csr_re, req_csr_we, req_csr_num, req_wmask, req_wvalue,
           req_ex, req_ecode, req_esubcode, req_ertn, req_pc, req_badv,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_csr_re, req_csr_we, req_csr_num, req_wmask, req_wvalue,
           req_ex, req_ecode, req_esubcode, req_ertn, req_pc, req_badv,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/csr_port_sched.sv
// Serialises CSR ops, exception entry and ertn onto the single CSR-file port; emits a one-cycle flush.
// CSR_SCHED_BADV_EN: ADEF/ALE exceptions also write BADV after ESTAT.
//
// state          | meaning
// S_IDLE         | ready for a WB op
// S_CSR          | plain csrrd/csrwr/csrxchg port access, response pulse
// S_EX_ERA       | write ERA <= pc
// S_EX_CRMD_RD   | read CRMD, latch PLV/IE
// S_EX_PRMD      | write PRMD[2:0] <= latched PLV/IE
// S_EX_CRMD      | write CRMD[2:0] <= 0
// S_EX_ESTAT     | write ESTAT {esubcode,ecode}
// S_EX_BADV      | write BADV <= badv (CSR_SCHED_BADV_EN only)
// S_EX_ENTRY     | read EENTRY as redirect target
// S_ERTN_PRMD_RD | read PRMD, latch PLV/IE
// S_ERTN_CRMD    | write CRMD[2:0] <= latched PLV/IE
// S_ERTN_ERA_RD  | read ERA as redirect target
module csr_port_sched
  import csr_port_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  csr_port_sched_if.slave      wb,
  output logic [CSR_NUM_W-1:0] csr_num,
  output logic                 csr_re,
  input  logic [DATA_W-1:0]    csr_rvalue,
  output logic                 csr_we,
  output logic [DATA_W-1:0]    csr_wmask,
  output logic [DATA_W-1:0]    csr_wvalue,
  output logic                 flush,
  output logic [DATA_W-1:0]    flush_target
);

  state_e               state_q, state_nxt;
  logic                 accept;
  logic                 cap_we;
  logic [CSR_NUM_W-1:0] cap_num;
  logic [DATA_W-1:0]    cap_wmask;
  logic [DATA_W-1:0]    cap_wvalue;
  logic [5:0]           cap_ecode;
  logic [8:0]           cap_esubcode;
  logic [DATA_W-1:0]    cap_pc;
  logic [2:0]           plv_ie_q;

`ifdef CSR_SCHED_BADV_EN
  logic [DATA_W-1:0]    cap_badv;
`else
  logic                 unused_badv;
  assign unused_badv = ^wb.req_badv;
`endif

  assign accept = wb.req_valid & wb.req_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cap_we       <= 1'b0;
      cap_num      <= '0;
      cap_wmask    <= '0;
      cap_wvalue   <= '0;
      cap_ecode    <= '0;
      cap_esubcode <= '0;
      cap_pc       <= '0;
      plv_ie_q     <= '0;
      flush        <= 1'b0;
      flush_target <= '0;
`ifdef CSR_SCHED_BADV_EN
      cap_badv     <= '0;
`endif
    end else begin
      state_q <= state_nxt;
      flush   <= 1'b0;
      if (accept) begin
        cap_we       <= wb.req_csr_we;
        cap_num      <= wb.req_csr_num;
        cap_wmask    <= wb.req_wmask;
        cap_wvalue   <= wb.req_wvalue;
        cap_ecode    <= wb.req_ecode;
        cap_esubcode <= wb.req_esubcode;
        cap_pc       <= wb.req_pc;
`ifdef CSR_SCHED_BADV_EN
        cap_badv     <= wb.req_badv;
`endif
      end
      if (state_q == S_EX_CRMD_RD || state_q == S_ERTN_PRMD_RD)
        plv_ie_q <= csr_rvalue[2:0];
      if (state_q == S_EX_ENTRY || state_q == S_ERTN_ERA_RD) begin
        flush        <= 1'b1;
        flush_target <= csr_rvalue;
      end
    end
  end

  always_comb begin
    state_nxt    = state_q;
    wb.req_ready = (state_q == S_IDLE);
    wb.rsp_valid = 1'b0;
    wb.rsp_rdata = '0;
    csr_num      = '0;
    csr_re       = 1'b0;
    csr_we       = 1'b0;
    csr_wmask    = '0;
    csr_wvalue   = '0;
    case (state_q)
      S_IDLE: begin
        // exception wins over ertn, which wins over a plain access
        if (wb.req_valid) begin
          if (wb.req_ex)                          state_nxt = S_EX_ERA;
          else if (wb.req_ertn)                   state_nxt = S_ERTN_PRMD_RD;
          else if (wb.req_csr_re | wb.req_csr_we) state_nxt = S_CSR;
        end
      end
      S_CSR: begin
        csr_num      = cap_num;
        csr_re       = 1'b1;
        csr_we       = cap_we;
        csr_wmask    = cap_wmask;
        csr_wvalue   = cap_wvalue;
        wb.rsp_valid = 1'b1;
        wb.rsp_rdata = csr_rvalue;
        state_nxt    = S_IDLE;
      end
      S_EX_ERA: begin
        csr_num    = CSR_ERA;
        csr_we     = 1'b1;
        csr_wmask  = MASK_ALL;
        csr_wvalue = cap_pc;
        state_nxt  = S_EX_CRMD_RD;
      end
      S_EX_CRMD_RD: begin
        csr_num   = CSR_CRMD;
        csr_re    = 1'b1;
        state_nxt = S_EX_PRMD;
      end
      S_EX_PRMD: begin
        csr_num    = CSR_PRMD;
        csr_we     = 1'b1;
        csr_wmask  = MASK_PLV_IE;
        csr_wvalue = {29'd0, plv_ie_q};
        state_nxt  = S_EX_CRMD;
      end
      S_EX_CRMD: begin
        csr_num    = CSR_CRMD;
        csr_we     = 1'b1;
        csr_wmask  = MASK_PLV_IE;
        csr_wvalue = '0;
        state_nxt  = S_EX_ESTAT;
      end
      S_EX_ESTAT: begin
        csr_num    = CSR_ESTAT;
        csr_we     = 1'b1;
        csr_wmask  = MASK_ESTAT_CODE;
        csr_wvalue = {1'b0, cap_esubcode, cap_ecode, 16'd0};
`ifdef CSR_SCHED_BADV_EN
        state_nxt  = ecode_has_badv(cap_ecode) ? S_EX_BADV : S_EX_ENTRY;
`else
        state_nxt  = S_EX_ENTRY;
`endif
      end
`ifdef CSR_SCHED_BADV_EN
      S_EX_BADV: begin
        csr_num    = CSR_BADV;
        csr_we     = 1'b1;
        csr_wmask  = MASK_ALL;
        csr_wvalue = cap_badv;
        state_nxt  = S_EX_ENTRY;
      end
`endif
      S_EX_ENTRY: begin
        csr_num   = CSR_EENTRY;
        csr_re    = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERTN_PRMD_RD: begin
        csr_num   = CSR_PRMD;
        csr_re    = 1'b1;
        state_nxt = S_ERTN_CRMD;
      end
      S_ERTN_CRMD: begin
        csr_num    = CSR_CRMD;
        csr_we     = 1'b1;
        csr_wmask  = MASK_PLV_IE;
        csr_wvalue = {29'd0, plv_ie_q};
        state_nxt  = S_ERTN_ERA_RD;
      end
      S_ERTN_ERA_RD: begin
        csr_num   = CSR_ERA;
        csr_re    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_port_sched.sv
// Bench for csr_port_sched: owns a CSR-file model, checks pulses, latencies and CSR contents against rule-level expectations.
`timescale 1ns/1ps
module tb_csr_port_sched;

  localparam logic [13:0] A_CRMD = 14'h0, A_PRMD = 14'h1, A_ESTAT = 14'h5;
  localparam logic [13:0] A_ERA = 14'h6, A_BADV = 14'h7, A_EENTRY = 14'hC;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [13:0] csr_num;
  logic        csr_re, csr_we, flush;
  logic [31:0] csr_wmask, csr_wvalue, csr_rvalue, flush_target;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  csr_port_sched_if wb();

  csr_port_sched dut (
    .clk          (clk),
    .resetn       (resetn),
    .wb           (wb),
    .csr_num      (csr_num),
    .csr_re       (csr_re),
    .csr_rvalue   (csr_rvalue),
    .csr_we       (csr_we),
    .csr_wmask    (csr_wmask),
    .csr_wvalue   (csr_wvalue),
    .flush        (flush),
    .flush_target (flush_target)
  );

  // CSR file seen by the DUT, plus the bench's expected image of it
  logic [31:0] csr_mem [0:16383];
  logic [31:0] exp_mem [0:16383];
  logic        do_init = 1'b0;
  logic        poke_en = 1'b0;
  logic [13:0] poke_addr = '0;
  logic [31:0] poke_data = '0;

  assign csr_rvalue = csr_mem[csr_num];

  always @(posedge clk) begin
    if (do_init) begin
      for (int i = 0; i < 16384; i++) csr_mem[i] <= {i[15:0], ~i[15:0]} ^ 32'h5A5A_1234;
    end else if (poke_en) begin
      csr_mem[poke_addr] <= poke_data;
    end else if (csr_we) begin
      csr_mem[csr_num] <= (csr_mem[csr_num] & ~csr_wmask) | (csr_wvalue & csr_wmask);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic prev_flush = 1'b0;
  always @(negedge clk) begin
    if (resetn) begin
      total++;
      assert (!(wb.rsp_valid && flush) && !(flush && prev_flush)) else begin
        bad++;
        $error("FAIL pulse_overlap observed=rsp%b/flush%b/prev%b expected=exclusive single pulses",
               wb.rsp_valid, flush, prev_flush);
      end
    end
    prev_flush = flush;
  end

  task automatic poke(input logic [13:0] a, input logic [31:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
    exp_mem[a] = d;
  endtask

  task automatic chk_mem(input string tag);
    int first_bad = -1;
    for (int i = 0; i < 16384; i++)
      if (first_bad < 0 && csr_mem[i] !== exp_mem[i]) first_bad = i;
    if (first_bad < 0) chk({tag, "_mem"}, 32'd0, 32'd0 + 32'(first_bad + 1));
    else chk({tag, "_mem"}, csr_mem[first_bad], exp_mem[first_bad]);
  endtask

  task automatic drive(input logic ex, input logic ertn, input logic re, input logic we,
                       input logic [13:0] num, input logic [31:0] mask, input logic [31:0] wval,
                       input logic [5:0] ecode, input logic [8:0] esub,
                       input logic [31:0] pc, input logic [31:0] badv);
    wb.req_valid = 1'b1; wb.req_ex = ex; wb.req_ertn = ertn;
    wb.req_csr_re = re; wb.req_csr_we = we; wb.req_csr_num = num;
    wb.req_wmask = mask; wb.req_wvalue = wval; wb.req_ecode = ecode;
    wb.req_esubcode = esub; wb.req_pc = pc; wb.req_badv = badv;
  endtask

  task automatic apply_ex_model(input logic [5:0] ecode, input logic [8:0] esub,
                                input logic [31:0] pc, input logic [31:0] badv, output int cyc);
    exp_mem[A_ERA]   = pc;
    exp_mem[A_PRMD]  = (exp_mem[A_PRMD] & ~32'h7) | (exp_mem[A_CRMD] & 32'h7);
    exp_mem[A_CRMD]  = exp_mem[A_CRMD] & ~32'h7;
    exp_mem[A_ESTAT] = (exp_mem[A_ESTAT] & 32'h8000_FFFF) | ({17'd0, esub, ecode} << 16);
    cyc = 7;
`ifdef CSR_SCHED_BADV_EN
    if (ecode == 6'h08 || ecode == 6'h09) begin
      exp_mem[A_BADV] = badv;
      cyc = 8;
    end
`else
    if (badv == 32'hDEAD_0000) cyc = 7;
`endif
  endtask

  // Starts at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_op(input string tag, input logic ex, input logic ertn, input logic re, input logic we,
                        input logic [13:0] num, input logic [31:0] mask, input logic [31:0] wval,
                        input logic [5:0] ecode, input logic [8:0] esub,
                        input logic [31:0] pc, input logic [31:0] badv);
    int exp_cyc = 0;
    logic exp_rsp = 1'b0, exp_flush = 1'b0;
    logic [31:0] exp_data = '0;
    int got_cyc = 0;
    logic got_rsp = 1'b0, got_flush = 1'b0, got_ready = 1'b0;
    logic [31:0] got_data = '0;
    int early_ready = 0;

    if (ex) begin
      apply_ex_model(ecode, esub, pc, badv, exp_cyc);
      exp_flush = 1'b1;
      exp_data  = exp_mem[A_EENTRY];
    end else if (ertn) begin
      exp_mem[A_CRMD] = (exp_mem[A_CRMD] & ~32'h7) | (exp_mem[A_PRMD] & 32'h7);
      exp_cyc = 4; exp_flush = 1'b1; exp_data = exp_mem[A_ERA];
    end else if (re || we) begin
      exp_data = exp_mem[num];
      if (we) exp_mem[num] = (exp_mem[num] & ~mask) | (wval & mask);
      exp_cyc = 1; exp_rsp = 1'b1;
    end

    chk({tag, "_ready_idle"}, 32'(wb.req_ready), 32'd1);
    drive(ex, ertn, re, we, num, mask, wval, ecode, esub, pc, badv);
    @(negedge clk);
    wb.req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 1 && exp_rsp)
        chk({tag, "_port"}, {16'(csr_num), 14'd0, csr_re, csr_we}, {16'(num), 14'd0, 1'b1, we});
      if (wb.rsp_valid || flush) begin
        got_cyc = c; got_rsp = wb.rsp_valid; got_flush = flush; got_ready = wb.req_ready;
        got_data = flush ? flush_target : wb.rsp_rdata;
        break;
      end
      if (wb.req_ready !== 1'b0) early_ready++;
      @(negedge clk);
    end

    chk({tag, "_latency"}, 32'(got_cyc), 32'(exp_cyc));
    if (exp_cyc != 0) begin
      chk({tag, "_kind"}, {30'd0, got_rsp, got_flush}, {30'd0, exp_rsp, exp_flush});
      chk({tag, "_data"}, got_data, exp_data);
      chk({tag, "_busy"}, 32'(early_ready), 32'd0);
      chk({tag, "_ready_evt"}, 32'(got_ready), 32'(exp_flush));
      if (exp_rsp) @(negedge clk);
    end
    chk_mem(tag);
  endtask

  initial begin
    logic [13:0] pick [0:6];
    int rst_cyc;
    int flush_seen;
    logic [13:0] rn;
    int kind;

    wb.req_valid = 1'b0; wb.req_ex = 1'b0; wb.req_ertn = 1'b0;
    wb.req_csr_re = 1'b0; wb.req_csr_we = 1'b0; wb.req_csr_num = '0;
    wb.req_wmask = '0; wb.req_wvalue = '0; wb.req_ecode = '0;
    wb.req_esubcode = '0; wb.req_pc = '0; wb.req_badv = '0;

    do_init = 1'b1;
    @(negedge clk);
    do_init = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16384; i++) exp_mem[i] = csr_mem[i];

    chk("reset_ctrl", {26'd0, wb.req_ready, wb.rsp_valid, flush, csr_re, csr_we, 1'b0}, 32'b100000);
    chk("reset_rdata", wb.rsp_rdata, 32'd0);
    chk("reset_target", flush_target, 32'd0);
    chk("reset_port", {18'(csr_num), 14'd0} | csr_wmask | csr_wvalue, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // plain csrwr
    poke(A_EENTRY, 32'h1C00_0000);
    run_op("csrwr", 0, 0, 0, 1, A_EENTRY, 32'hFFFF_FFFF, 32'h1C00_8000, 6'h0, 9'h0, 32'h0, 32'h0);

    // exception entry
    poke(A_CRMD, 32'h0000_0007);
    run_op("ex_basic", 1, 0, 0, 0, 14'h0, 32'h0, 32'h0, 6'h0B, 9'h0, 32'h1C00_0100, 32'h0);

    // ertn
    poke(A_PRMD, 32'h0000_0003);
    poke(A_ERA, 32'h1C00_0104);
    run_op("ertn", 0, 1, 0, 0, 14'h0, 32'h0, 32'h0, 6'h0, 9'h0, 32'h0, 32'h0);

    // exception suppresses own write; ex wins over ertn; back-to-back from flush cycle
    run_op("ex_we", 1, 0, 1, 1, A_EENTRY, 32'hFFFF_FFFF, 32'h0BAD_0BAD, 6'h01, 9'h1A5, 32'h1C00_0200, 32'h0);
    run_op("ex_ertn", 1, 1, 0, 0, 14'h0, 32'h0, 32'h0, 6'h02, 9'h0, 32'h1C00_0300, 32'h0);
    run_op("b2b_rd", 0, 0, 1, 0, A_ERA, 32'h0, 32'h0, 6'h0, 9'h0, 32'h0, 32'h0);

    // ALE with BADV
    poke(A_BADV, 32'h7777_7777);
    run_op("ex_ale", 1, 0, 0, 0, 14'h0, 32'h0, 32'h0, 6'h09, 9'h0, 32'h1C00_0400, 32'h0000_0003);

    // no-op accept
    run_op("noop", 0, 0, 0, 0, 14'h0, 32'h0, 32'h0, 6'h0, 9'h0, 32'h0, 32'h0);

    // reset mid exception at EX_CRMD
    poke(A_CRMD, 32'h0000_0005);
    exp_mem[A_ERA]  = 32'h1C00_0500;
    exp_mem[A_PRMD] = (exp_mem[A_PRMD] & ~32'h7) | 32'h5;
    drive(1, 0, 0, 0, 14'h0, 32'h0, 32'h0, 6'h0B, 9'h0, 32'h1C00_0500, 32'h0);
    @(negedge clk);
    wb.req_valid = 1'b0;
    for (rst_cyc = 1; rst_cyc < 4; rst_cyc++) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst_mid_ctrl", {26'd0, wb.req_ready, wb.rsp_valid, flush, csr_re, csr_we, 1'b0}, 32'b100000);
    chk("rst_mid_port", {18'(csr_num), 14'd0} | csr_wmask | csr_wvalue | flush_target, 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    flush_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (flush) flush_seen++;
    end
    chk("rst_mid_noflush", 32'(flush_seen), 32'd0);
    chk_mem("rst_mid");

    // randomized mix
    pick[0] = A_CRMD; pick[1] = A_PRMD; pick[2] = A_ESTAT; pick[3] = A_ERA;
    pick[4] = A_BADV; pick[5] = A_EENTRY; pick[6] = 14'h0;
    for (int n = 0; n < 40; n++) begin
      rn = pick[$urandom_range(0, 6)];
      if (rn == 14'h0 && $urandom_range(0, 1) == 1) rn = 14'($urandom_range(16, 16383));
      kind = $urandom_range(0, 9);
      if (kind <= 4)
        run_op("rnd_csr", 0, 0, 1'($urandom_range(0, 1)), 1, rn, $urandom, $urandom,
               6'h0, 9'h0, 32'h0, 32'h0);
      else if (kind <= 6)
        run_op("rnd_ex", 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               rn, $urandom, $urandom, 6'($urandom_range(0, 12)), 9'($urandom), $urandom, $urandom);
      else if (kind <= 8)
        run_op("rnd_ertn", 0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               rn, $urandom, $urandom, 6'h0, 9'h0, 32'h0, 32'h0);
      else
        run_op("rnd_rd", 0, 0, 1, 0, rn, 32'h0, 32'h0, 6'h0, 9'h0, 32'h0, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
